// File: rtl/bingo_pkg.sv
// bingo_pkg: shared types and constants for the Bingo turn controller.
package bingo_pkg;
  typedef enum logic [2:0] {ST_ENTRY, ST_SCAN, ST_COUNT, ST_REPORT, ST_WON} state_e;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int N_CELLS = 25;
  localparam int N_LINES = 12;
  // rows 0-4, columns 0-4, main diagonal, anti-diagonal; bit i = row*5+col
  localparam logic [N_CELLS-1:0] LINE_MASK [N_LINES] = '{
    25'h000001F, 25'h00003E0, 25'h0007C00, 25'h00F8000, 25'h1F00000,
    25'h0108421, 25'h0210842, 25'h0421084, 25'h0842108, 25'h1084210,
    25'h1041041, 25'h0111110
  };
endpackage

// File: rtl/bingo_line_counter.sv
// bingo_line_counter: serial line checker, one of the twelve 5-cell lines per cycle.
module bingo_line_counter
  import bingo_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [N_CELLS-1:0] map_i,
  output logic               done_o,
  output logic [3:0]         count_o
);
  logic       busy_q;
  logic [3:0] step_q;
  logic [3:0] acc_q;
  logic       full;
  assign full    = (map_i & LINE_MASK[step_q]) == LINE_MASK[step_q];
  assign count_o = acc_q + {3'd0, full};
  assign done_o  = busy_q && step_q == 4'(N_LINES - 1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      step_q <= 4'd0;
      acc_q  <= 4'd0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      step_q <= 4'd0;
      acc_q  <= 4'd0;
    end else if (busy_q) begin
      acc_q  <= count_o;
      step_q <= step_q + 4'd1;
      busy_q <= !done_o;
    end
  end
endmodule

// File: rtl/bingo_turn_ctrl.sv
// bingo_turn_ctrl: Bingo turn sequencing -- keypad entry, remote calls, serial
// card scan/mark, line recount and turn hand-over.
module bingo_turn_ctrl
  import bingo_pkg::*;
#(
  parameter int unsigned WIN_LINES  = 5,
  parameter bit          FIRST_TURN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         key_valid_i,
  input  logic [3:0]   key_code_i,
  input  logic [124:0] board_vals_i,
  input  logic         remote_valid_i,
  input  logic [4:0]   remote_num_i,
  output logic [24:0]  map_o,
  output logic [15:0]  nums_o,
  output logic         my_turn_o,
  output logic         send_valid_o,
  output logic [4:0]   send_num_o,
  output logic         err_o,
  output logic         win_o
);
  localparam logic [4:0] WIN_L    = 5'(WIN_LINES);
  localparam logic [4:0] LAST_IDX = 5'(N_CELLS - 1);
  state_e             state_q;
  logic [1:0]         cnt_q;
  logic [3:0]         tens_q, ones_q;
  logic [4:0]         target_q, idx_q, hit_idx_q, send_num_q;
  logic               local_q, found_q, hit_marked_q;
  logic [N_CELLS-1:0] map_q;
  logic [3:0]         lines_q;
  logic               my_turn_q, send_valid_q, err_q, win_q;
  logic [6:0]         entry_val, cell_lsb;
  logic               entry_ok, cur_match, found_d, hit_marked_d, scan_last, scan_rej;
  logic [4:0]         hit_idx_d;
  logic               lc_start, lc_done;
  logic [3:0]         lc_count;
  logic [7:0]         buf_bcd, lines_bcd;
  assign entry_val    = cnt_q == 2'd2 ? 7'(tens_q) * 7'd10 + 7'(ones_q) : 7'(ones_q);
  assign entry_ok     = entry_val >= 7'd1 && entry_val <= 7'd25;
  assign cell_lsb     = 7'(idx_q) * 7'd5;
  assign cur_match    = board_vals_i[cell_lsb +: 5] == target_q;
  // first match wins; later duplicates on the card are ignored
  assign found_d      = found_q | cur_match;
  assign hit_idx_d    = found_q ? hit_idx_q : idx_q;
  assign hit_marked_d = found_q ? hit_marked_q : map_q[idx_q];
  assign scan_last    = state_q == ST_SCAN && idx_q == LAST_IDX;
  assign scan_rej     = local_q && (!found_d || hit_marked_d);
  assign lc_start     = scan_last && !scan_rej;
  assign buf_bcd      = cnt_q == 2'd0 ? {BCD_BLANK, BCD_BLANK} :
                        cnt_q == 2'd1 ? {BCD_BLANK, ones_q} : {tens_q, ones_q};
  assign lines_bcd    = lines_q >= 4'd10 ? {4'd1, lines_q - 4'd10} : {4'd0, lines_q};
  assign nums_o       = {buf_bcd, lines_bcd};
  assign map_o        = map_q;
  assign my_turn_o    = my_turn_q;
  assign send_valid_o = send_valid_q;
  assign send_num_o   = send_num_q;
  assign err_o        = err_q;
  assign win_o        = win_q;
  bingo_line_counter u_lines (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (lc_start),
    .map_i   (map_q),
    .done_o  (lc_done),
    .count_o (lc_count)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_ENTRY;
      cnt_q        <= 2'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      target_q     <= 5'd0;
      idx_q        <= 5'd0;
      hit_idx_q    <= 5'd0;
      local_q      <= 1'b0;
      found_q      <= 1'b0;
      hit_marked_q <= 1'b0;
      map_q        <= '0;
      lines_q      <= 4'd0;
      my_turn_q    <= FIRST_TURN;
      send_valid_q <= 1'b0;
      send_num_q   <= 5'd0;
      err_q        <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      err_q        <= 1'b0;
      send_valid_q <= 1'b0;
      case (state_q)
        ST_ENTRY: begin
          if (my_turn_q && key_valid_i) begin
            if (key_code_i < 4'd10 && cnt_q != 2'd2) begin
              tens_q <= ones_q;
              ones_q <= key_code_i;
              cnt_q  <= cnt_q + 2'd1;
            end else if (key_code_i == KEY_BACK && cnt_q != 2'd0) begin
              ones_q <= tens_q;
              cnt_q  <= cnt_q - 2'd1;
            end else if (key_code_i == KEY_ENTER && cnt_q != 2'd0) begin
              if (entry_ok) begin
                target_q <= entry_val[4:0];
                local_q  <= 1'b1;
                idx_q    <= 5'd0;
                found_q  <= 1'b0;
                state_q  <= ST_SCAN;
              end else begin
                err_q <= 1'b1;
                cnt_q <= 2'd0;
              end
            end
          end else if (!my_turn_q && remote_valid_i) begin
            target_q <= remote_num_i;
            local_q  <= 1'b0;
            idx_q    <= 5'd0;
            found_q  <= 1'b0;
            state_q  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          idx_q        <= idx_q + 5'd1;
          found_q      <= found_d;
          hit_idx_q    <= hit_idx_d;
          hit_marked_q <= hit_marked_d;
          if (scan_last && scan_rej) begin
            err_q   <= 1'b1;
            cnt_q   <= 2'd0;
            state_q <= ST_ENTRY;
          end else if (scan_last) begin
            if (found_d && !hit_marked_d) map_q[hit_idx_d] <= 1'b1;
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (lc_done) begin
            lines_q <= lc_count;
            state_q <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          send_valid_q <= local_q;
          if (local_q) send_num_q <= target_q;
          cnt_q     <= 2'd0;
          my_turn_q <= !my_turn_q;
          if ({1'b0, lines_q} >= WIN_L) begin
            win_q   <= 1'b1;
            state_q <= ST_WON;
          end else begin
            state_q <= ST_ENTRY;
          end
        end
        ST_WON: ;
        default: state_q <= ST_ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_bingo_turn_ctrl.sv
// tb_bingo_turn_ctrl: randomized game play against a card-level reference model;
// expected send/err pulses are queued with their due cycle and popped by a monitor.
module tb_bingo_turn_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic [124:0] board_vals = '0;
  logic         remote_valid = 1'b0;
  logic [4:0]   remote_num = 5'd0;
  logic [24:0]  map;
  logic [15:0]  nums;
  logic         my_turn, send_valid, err, win;
  logic [4:0]   send_num;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bingo_turn_ctrl #(.WIN_LINES(5), .FIRST_TURN(1'b1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .key_valid_i    (key_valid),
    .key_code_i     (key_code),
    .board_vals_i   (board_vals),
    .remote_valid_i (remote_valid),
    .remote_num_i   (remote_num),
    .map_o          (map),
    .nums_o         (nums),
    .my_turn_o      (my_turn),
    .send_valid_o   (send_valid),
    .send_num_o     (send_num),
    .err_o          (err),
    .win_o          (win)
  );

  typedef struct {bit is_err; int num; int at;} ev_t;
  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  bval[25];
  bit  mk[25];
  int  buf_m[$];
  int  lines_m;
  bit  turn_m, won_m;

  function automatic int find(int v);
    for (int i = 0; i < 25; i++) if (bval[i] == v) return i;
    return -1;
  endfunction

  function automatic int count_lines();
    int n = 0;
    bit r, c, d, a;
    d = 1'b1;
    a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r = 1'b1;
      c = 1'b1;
      for (int j = 0; j < 5; j++) begin
        r &= mk[i*5+j];
        c &= mk[j*5+i];
      end
      if (r) n++;
      if (c) n++;
      d &= mk[i*6];
      a &= mk[i*4+4];
    end
    if (d) n++;
    if (a) n++;
    return n;
  endfunction

  function automatic void finish_turn(int idx);
    if (idx >= 0) mk[idx] = 1'b1;
    lines_m = count_lines();
    turn_m = !turn_m;
    if (lines_m >= 5) won_m = 1'b1;
  endfunction

  // c = cycle count at the negedge the key is driven; the DUT samples it one edge later
  function automatic void model_key(logic [3:0] code, int c);
    int v, idx;
    if (won_m || !turn_m) return;
    if (code < 4'd10) begin
      if (buf_m.size() < 2) buf_m.push_back(int'(code));
    end else if (code == 4'hB) begin
      if (buf_m.size() > 0) void'(buf_m.pop_back());
    end else if (code == 4'hA && buf_m.size() > 0) begin
      v = buf_m.size() == 2 ? buf_m[0] * 10 + buf_m[1] : buf_m[0];
      buf_m.delete();
      idx = find(v);
      if (v < 1 || v > 25) sb.push_back('{1'b1, 0, c + 1});
      else if (idx < 0 || mk[idx]) sb.push_back('{1'b1, 0, c + 26});
      else begin
        finish_turn(idx);
        sb.push_back('{1'b0, v, c + 39});
      end
    end
  endfunction

  function automatic void model_remote(int n);
    int idx;
    if (won_m || turn_m) return;
    idx = find(n);
    finish_turn((idx >= 0 && !mk[idx]) ? idx : -1);
  endfunction

  function automatic void model_clear();
    sb.delete();
    buf_m.delete();
    foreach (mk[i]) mk[i] = 1'b0;
    lines_m = 0;
    turn_m = 1'b1;
    won_m = 1'b0;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] need);
    n_cmp++;
    if (got !== need) begin
      n_bad++;
      $display("FAIL %s: got %h need %h", name, got, need);
    end
  endtask

  task automatic check_state(string tag);
    logic [24:0] m;
    logic [7:0]  b;
    m = '0;
    for (int i = 0; i < 25; i++) m[i] = mk[i];
    b = buf_m.size() == 0 ? 8'hFF :
        buf_m.size() == 1 ? {4'hF, 4'(buf_m[0])} : {4'(buf_m[0]), 4'(buf_m[1])};
    chk({tag, ".map"}, 32'(map), 32'(m));
    chk({tag, ".turn"}, 32'(my_turn), 32'(turn_m));
    chk({tag, ".nums"}, 32'(nums), {16'd0, b, 4'(lines_m / 10), 4'(lines_m % 10)});
    chk({tag, ".win"}, 32'(win), 32'(won_m));
  endtask

  task automatic press(logic [3:0] code);
    model_key(code, cyc);
    key_code = code;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter();
    press(4'hA);
    tick(42);
  endtask

  task automatic call(int v);
    if (v >= 10) press(4'(v / 10));
    press(4'(v % 10));
    enter();
  endtask

  task automatic remote(logic [4:0] n);
    model_remote(int'(n));
    remote_num = n;
    remote_valid = 1'b1;
    @(negedge clk);
    remote_valid = 1'b0;
    tick(42);
  endtask

  task automatic both(logic [3:0] code, logic [4:0] n);
    if (turn_m) model_key(code, cyc);
    else model_remote(int'(n));
    key_code = code;
    remote_num = n;
    key_valid = 1'b1;
    remote_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    remote_valid = 1'b0;
    tick(42);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic load_board(bit shuffle);
    int j, t;
    for (int i = 0; i < 25; i++) bval[i] = i + 1;
    if (shuffle) begin
      for (int i = 24; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = bval[i];
        bval[i] = bval[j];
        bval[j] = t;
      end
    end
    for (int i = 0; i < 25; i++) board_vals[5*i +: 5] = 5'(bval[i]);
  endtask

  initial begin
    int r, v;
    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (rst_n && (send_valid || err)) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL pulse: unexpected send_valid=%0b err=%0b num=%0d at cycle %0d",
                     send_valid, err, send_num, cyc);
          end else begin
            e = sb.pop_front();
            if (send_valid !== !e.is_err || err !== e.is_err || cyc != e.at ||
                (!e.is_err && int'(send_num) != e.num)) begin
              n_bad++;
              $display("FAIL pulse: got send_valid=%0b err=%0b num=%0d cycle %0d, need err=%0b num=%0d cycle %0d",
                       send_valid, err, send_num, cyc, e.is_err, e.num, e.at);
            end
          end
        end
      end
    join_none

    load_board(1'b0);
    do_reset();
    chk("rst.map", 32'(map), 32'd0);
    chk("rst.nums", 32'(nums), 32'h0000FF00);
    chk("rst.turn", 32'(my_turn), 32'd1);
    chk("rst.win", 32'(win), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.send", 32'(send_valid), 32'd0);
    chk("rst.num", 32'(send_num), 32'd0);

    press(4'd1);
    press(4'd3);
    chk("buf13", 32'(nums[15:8]), 32'h13);
    press(4'hA);
    tick(24);
    chk("map12_early", 32'(map[12]), 32'd0);
    tick(1);
    chk("map12_k26", 32'(map[12]), 32'd1);
    tick(17);
    check_state("call13");
    chk("call13.nums", 32'(nums), 32'h0000FF00);

    press(4'd5);
    press(4'd5);
    remote(5'd7);
    check_state("rem7");

    press(4'd2);
    press(4'd9);
    enter();
    check_state("rej29");

    press(4'd4);
    press(4'd5);
    press(4'hB);
    chk("bs.buf", 32'(nums[15:8]), 32'h000000F4);
    check_state("bs");
    press(4'd6);
    enter();
    check_state("rej46");
    press(4'd4);
    enter();
    check_state("call4");

    remote(5'd20);
    check_state("rem20");
    call(13);
    check_state("dup13");
    remote(5'd9);
    check_state("drop_rem");
    both(4'd8, 5'd9);
    press(4'hB);
    check_state("both");

    for (int k = 1; k <= 25 && !won_m; k++) begin
      if (!mk[find(k)]) begin
        if (turn_m) call(k);
        else remote(5'(k));
        check_state($sformatf("fill%0d", k));
      end
    end
    chk("won", 32'(win), 32'd1);
    press(4'd1);
    enter();
    remote(5'd2);
    check_state("won_hold");

    do_reset();
    check_state("rst2");
    press(4'd1);
    press(4'd7);
    press(4'hA);
    tick(29);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst.map", 32'(map), 32'd0);
    chk("midrst.nums", 32'(nums), 32'h0000FF00);
    chk("midrst.turn", 32'(my_turn), 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_state("midrst");
    call(17);
    check_state("after_midrst");

    for (int g = 0; g < 3; g++) begin
      load_board(1'b1);
      do_reset();
      for (int s = 0; s < 70 && !won_m; s++) begin
        r = int'($urandom_range(9, 0));
        if (turn_m) begin
          if (r < 7) begin
            v = int'($urandom_range(30, 0));
            if (v < 10 && r == 0) press(4'd0);
            call(v);
          end else if (r < 9) begin
            press(4'($urandom_range(15, 0)));
            if (key_code == 4'hA) tick(42);
          end else begin
            both(4'($urandom_range(15, 0)), 5'($urandom_range(31, 0)));
          end
        end else begin
          if (r < 6) remote(5'($urandom_range(25, 1)));
          else if (r < 8) remote(5'($urandom_range(31, 0)));
          else if (r == 8) begin
            press(4'($urandom_range(15, 0)));
            remote(5'($urandom_range(25, 1)));
          end else begin
            both(4'($urandom_range(15, 0)), 5'($urandom_range(25, 1)));
          end
        end
        check_state($sformatf("rnd%0d.%0d", g, s));
      end
    end

    tick(50);
    chk("pending", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
